// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dmem_arb_pkg : shared types and constants for the DATA_MEM arbiter    |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } arb_state_e;

   localparam int PORT_CPU = 0;
   localparam int PORT_DMA = 1;

   localparam int DEF_AW        = 32;
   localparam int DEF_DW        = 32;
   localparam int DEF_MAX_BURST = 4;

endpackage
`default_nettype wire

// File: rtl/dmem_arb_rdbuf.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dmem_arb_rdbuf : per-port registered read data and one-cycle rvalid   |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module dmem_arb_rdbuf #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          capture,
   input  logic [DW-1:0] r_data,
   output logic          rvalid,
   output logic [DW-1:0] rdata
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= capture;
         if (capture) begin
            rdata <= r_data;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dmem_arbiter : round-robin DATA_MEM arbiter with bounded burst lock   |
// | Optional macro DMEM_ARB_PERF_EN builds the conflict_cnt counter.      |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW        = DEF_AW,
   parameter int DW        = DEF_DW,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic          m0_lock,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic          m1_lock,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_write_en,
   output logic [DW-1:0] mem_w_data,
   input  logic [DW-1:0] mem_r_data,
   output logic [15:0]   conflict_cnt
);

   localparam logic [3:0] BURST_CAP = 4'(MAX_BURST);

   arb_state_e state, state_nx;
   logic       rr_ptr, rr_nx;
   logic [3:0] beat_cnt, beat_nx;
   logic       g0, g1, forced;

   always_comb begin
      g0     = 1'b0;
      g1     = 1'b0;
      forced = 1'b0;
      case (state)
         ST_OWN0: begin
            if (m0_req) begin
               if (beat_cnt < BURST_CAP || !m1_req) begin
                  g0 = 1'b1;
               end else begin
                  g1     = 1'b1;
                  forced = 1'b1;
               end
            end else begin
               g1 = m1_req;
            end
         end
         ST_OWN1: begin
            if (m1_req) begin
               if (beat_cnt < BURST_CAP || !m0_req) begin
                  g1 = 1'b1;
               end else begin
                  g0     = 1'b1;
                  forced = 1'b1;
               end
            end else begin
               g0 = m0_req;
            end
         end
         default: begin
            if (m0_req && m1_req) begin
               g0 = (rr_ptr == 1'(PORT_CPU));
               g1 = (rr_ptr == 1'(PORT_DMA));
            end else begin
               g0 = m0_req;
               g1 = m1_req;
            end
         end
      endcase
   end

   // Grants are combinational, so they must be squashed for the whole reset window.
   assign m0_gnt = g0 & ~reset;
   assign m1_gnt = g1 & ~reset;

   always_comb begin
      state_nx = ST_IDLE;
      beat_nx  = 4'd0;
      rr_nx    = rr_ptr;
      if (g0) begin
         if (m0_lock) begin
            state_nx = ST_OWN0;
            if (state == ST_OWN0) begin
               beat_nx = (beat_cnt >= BURST_CAP) ? BURST_CAP : beat_cnt + 4'd1;
            end else begin
               beat_nx = 4'd1;
            end
         end
         if (!m0_lock || forced) begin
            rr_nx = 1'(PORT_DMA);
         end
      end else if (g1) begin
         if (m1_lock) begin
            state_nx = ST_OWN1;
            if (state == ST_OWN1) begin
               beat_nx = (beat_cnt >= BURST_CAP) ? BURST_CAP : beat_cnt + 4'd1;
            end else begin
               beat_nx = 4'd1;
            end
         end
         if (!m1_lock || forced) begin
            rr_nx = 1'(PORT_CPU);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         rr_ptr   <= 1'b0;
         beat_cnt <= 4'd0;
      end else begin
         state    <= state_nx;
         rr_ptr   <= rr_nx;
         beat_cnt <= beat_nx;
      end
   end

   always_comb begin
      mem_addr     = '0;
      mem_w_data   = '0;
      mem_write_en = 1'b0;
      if (m0_gnt) begin
         mem_addr     = m0_addr;
         mem_w_data   = m0_wdata;
         mem_write_en = m0_req & m0_we;
      end else if (m1_gnt) begin
         mem_addr     = m1_addr;
         mem_w_data   = m1_wdata;
         mem_write_en = m1_req & m1_we;
      end
   end

   dmem_arb_rdbuf #(.DW(DW)) u_rdbuf0 (
      .clk     (clk),
      .reset   (reset),
      .capture (m0_gnt & ~m0_we),
      .r_data  (mem_r_data),
      .rvalid  (m0_rvalid),
      .rdata   (m0_rdata)
   );

   dmem_arb_rdbuf #(.DW(DW)) u_rdbuf1 (
      .clk     (clk),
      .reset   (reset),
      .capture (m1_gnt & ~m1_we),
      .r_data  (mem_r_data),
      .rvalid  (m1_rvalid),
      .rdata   (m1_rdata)
   );

`ifdef DMEM_ARB_PERF_EN
   logic stall;
   assign stall = (m0_req & ~m0_gnt) | (m1_req & ~m1_gnt);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         conflict_cnt <= 16'd0;
      end else if (stall && conflict_cnt != 16'hFFFF) begin
         conflict_cnt <= conflict_cnt + 16'd1;
      end
   end
`else
   assign conflict_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port DATA_MEM between two requesters: port 0 (CPU load/store) and port 1 (DMA/debug loader).
- Grants are round-robin, with optional bounded burst locking.
- Drives the memory's addr/write_en/w_data combinationally from the granted port. Returns registered read data one cycle later.
- Sits between the core/DMA and DATA_MEM; the memory reads asynchronously and writes on the rising clk edge.

Parameters:
- AW, 32, address width (matches DATA_MEM addr).
- DW, 32, data width.
- MAX_BURST, 4, maximum consecutive locked grants to one port before a forced hand-over; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  port 0 access request.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_lock  in  1  port 0 wants to keep ownership after this beat.
- m0_addr  in  AW  port 0 address.
- m0_wdata  in  DW  port 0 write data.
- m0_gnt  out  1  port 0 beat accepted this cycle (combinational).
- m0_rvalid  out  1  port 0 read data valid (registered).
- m0_rdata  out  DW  port 0 read data (registered).
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1.
- mem_addr  out  AW  to DATA_MEM addr.
- mem_write_en  out  1  to DATA_MEM write_en.
- mem_w_data  out  DW  to DATA_MEM w_data.
- mem_r_data  in  DW  from DATA_MEM r_data.
- conflict_cnt  out  16  stall-cycle counter (see Optional Feature).

Behaviour:
- Reset (async, active-high). State=IDLE, rr_ptr=0, beat_cnt=0, m*_rvalid=0, m*_rdata=0, conflict_cnt=0.
- While reset is asserted, m*_gnt=0, mem_write_en=0, mem_addr=0 and mem_w_data=0. An in-flight read is discarded.
- State machine (IDLE, OWN0, OWN1) and per-cycle grant decision:
  - IDLE: a single requester is granted. If both request, rr_ptr is granted.
  - OWNk with mk_req=1: port k is granted if beat_cnt<MAX_BURST or the other port is idle. Otherwise the other port is granted.
  - OWNk with mk_req=0: arbitrate as IDLE, with preference to the other port.
- At most one gnt per cycle. gnt never asserts without the corresponding req.
- Memory mux:
  - With a grant, mem_addr/mem_w_data follow the granted port and mem_write_en = req & we of that port.
  - With no grant, mem_write_en=0 and mem_addr/mem_w_data=0.
  - A write commits at the clk edge of the grant cycle.
- Reads: on a granted read, mem_r_data is captured at that clk edge into mk_rdata, and mk_rvalid=1 for exactly the next cycle.
  - mk_rdata holds its value until the next granted read to port k.
  - A granted write produces no rvalid.
- State update on each granted beat to port k:
  - mk_lock=1: next=OWNk. beat_cnt=beat_cnt+1 if already OWNk, else 1.
  - mk_lock=0: next=IDLE, beat_cnt=0, rr_ptr=other port.
  - Forced hand-over (other port granted out of OWNk): ownership passes per that port's lock. rr_ptr=k.
  - No grant in a cycle: next=IDLE, beat_cnt=0, rr_ptr unchanged.
- Width rules: beat_cnt is 4 bits and never exceeds MAX_BURST. Ownership is capped, so no wrap.
- Back-to-back: a requester may hold req high across cycles. Each granted cycle is one beat, and a denied req must be held stable by the requester.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined: conflict_cnt increments, saturating at 16'hFFFF, in every cycle where any req is high without its gnt.
- Undefined: conflict_cnt is tied to 0 and no counter flops are built.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - the state enum (ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2);
  - the port index constants (PORT_CPU=0, PORT_DMA=1);
  - the default width constants.
- One natural sub-module: dmem_arb_rdbuf, the per-port registered read-data/rvalid stage, instantiated twice.
- Grant logic and the FSM stay in the top.

Test Plan:
- Reset mid-read:
  - Stimulus: m0 read addr=2 granted, reset asserted before the next edge.
  - Required: m0_rvalid=0, m0_rdata=0, state IDLE, mem_write_en=0.
- Single port write/read:
  - Stimulus: m0 writes 20@0, 30@1, 40@2 (we=1, lock=0), then reads 0, 2, 1.
  - Required: m0_gnt=1 on each cycle; m0_rdata = 20, 40, 30 with m0_rvalid one cycle after each read grant.
- Contention, round-robin:
  - Stimulus: both ports read every cycle, lock=0.
  - Required: grants alternate m0, m1, m0, m1 from reset (rr_ptr=0); conflict_cnt=4 after 4 cycles when DMEM_ARB_PERF_EN is defined.
- Burst cap, MAX_BURST=4:
  - Stimulus: m1 writes with lock=1 continuously while m0 requests from cycle 1.
  - Required: m1 gets 4 consecutive grants, then m0 is granted; m1 regains the grant on the following cycle.
- Lock with idle competitor:
  - Stimulus: m0 lock=1 for 10 beats, m1_req=0.
  - Required: m0 is granted on all 10 cycles with no forced release.
- Write isolation:
  - Stimulus: same cycle, m0 write 55@3 and m1 write 77@3, rr_ptr=1.
  - Required: only m1 is granted and writes; m0 commits next cycle; read@3 returns 55.
